// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with write-back bypass, load-use
// hazard detection, hold/bubble/flush control and a saturating bubble counter.
module id_ex_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_use_rs,
    input  logic                      id_use_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_dest,
    input  logic                      id_reg_we,
    input  logic                      id_mem_read,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [DATA_WIDTH-1:0]     rf_read_data1,
    input  logic [DATA_WIDTH-1:0]     rf_read_data2,
    input  logic                      wb_we,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic                      flush,
    input  logic                      ex_hold,
    output logic                      id_stall,
    output logic                      ex_valid,
    output logic [DATA_WIDTH-1:0]     ex_rs_data,
    output logic [DATA_WIDTH-1:0]     ex_rt_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs,
    output logic [REG_ADDR_WIDTH-1:0] ex_rt,
    output logic [REG_ADDR_WIDTH-1:0] ex_dest,
    output logic                      ex_reg_we,
    output logic                      ex_mem_read,
    output logic [DATA_WIDTH-1:0]     ex_imm,
    output logic [CNT_WIDTH-1:0]      bubble_count
);
    logic [DATA_WIDTH-1:0] op1, op2;
    logic                  hazard;

    // The register file writes on the same edge, so a matching write-back must be bypassed.
    always_comb begin
        op1 = (id_rs == '0) ? '0 : (wb_we && wb_rd == id_rs) ? wb_data : rf_read_data1;
        op2 = (id_rt == '0) ? '0 : (wb_we && wb_rd == id_rt) ? wb_data : rf_read_data2;
        hazard = id_valid && ex_valid && ex_mem_read && ex_dest != '0 &&
                 ((id_use_rs && id_rs == ex_dest) || (id_use_rt && id_rt == ex_dest));
        id_stall = (hazard || ex_hold) && !flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid     <= 1'b0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_dest      <= '0;
            ex_reg_we    <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_imm       <= '0;
            bubble_count <= '0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_dest     <= '0;
            ex_reg_we   <= 1'b0;
            ex_mem_read <= 1'b0;
            ex_imm      <= '0;
        end else if (!ex_hold) begin
            if (hazard) begin
                ex_valid     <= 1'b0;
                ex_reg_we    <= 1'b0;
                ex_mem_read  <= 1'b0;
                bubble_count <= (&bubble_count) ? bubble_count : bubble_count + 1'b1;
            end else begin
                ex_valid    <= id_valid;
                ex_rs_data  <= op1;
                ex_rt_data  <= op2;
                ex_rs       <= id_rs;
                ex_rt       <= id_rt;
                ex_dest     <= id_dest;
                ex_reg_we   <= id_reg_we && id_valid;
                ex_mem_read <= id_mem_read && id_valid;
                ex_imm      <= id_imm;
            end
        end
    end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute boundary of the 5-stage pipelined core, directly downstream of the register file.
- Takes the two read ports of the register file plus decoded control, and applies a write-back bypass. The bypass is needed because the register file updates on the clock edge, so a same-cycle read returns the old value.
- Detects load-use hazards and registers everything into the ID/EX pipeline register, which supports hold, bubble and flush.
- Keeps a saturating count of inserted bubbles for performance observation.

Parameters:
- DATA_WIDTH, 32, operand/immediate width.
- REG_ADDR_WIDTH, 5, register index width (32 registers, r0 hard-wired zero).
- CNT_WIDTH, 16, width of bubble counter.

Ports:
- clk  input  1  pipeline clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset.
- id_valid  input  1  IF/ID holds a real instruction.
- id_rs  input  REG_ADDR_WIDTH  source register 1 index (same value driven to register file readRegister1).
- id_rt  input  REG_ADDR_WIDTH  source register 2 index.
- id_use_rs  input  1  instruction actually reads rs.
- id_use_rt  input  1  instruction actually reads rt.
- id_dest  input  REG_ADDR_WIDTH  destination register.
- id_reg_we  input  1  instruction writes the register file.
- id_mem_read  input  1  instruction is a load.
- id_imm  input  DATA_WIDTH  sign/zero-extended immediate.
- rf_read_data1  input  DATA_WIDTH  register file readData1.
- rf_read_data2  input  DATA_WIDTH  register file readData2.
- wb_we  input  1  write-back stage writing this cycle (drives register file we).
- wb_rd  input  REG_ADDR_WIDTH  write-back destination.
- wb_data  input  DATA_WIDTH  write-back data.
- flush  input  1  taken branch/jump resolved; kill instruction entering EX.
- ex_hold  input  1  EX stage busy; freeze ID/EX.
- id_stall  output  1  combinational; IF/ID and PC must hold when 1.
- ex_valid  output  1  ID/EX holds a real instruction.
- ex_rs_data  output  DATA_WIDTH  registered operand 1.
- ex_rt_data  output  DATA_WIDTH  registered operand 2.
- ex_rs  output  REG_ADDR_WIDTH  registered rs index (for EX forwarding).
- ex_rt  output  REG_ADDR_WIDTH  registered rt index.
- ex_dest  output  REG_ADDR_WIDTH  registered destination.
- ex_reg_we  output  1  registered write enable.
- ex_mem_read  output  1  registered load flag.
- ex_imm  output  DATA_WIDTH  registered immediate.
- bubble_count  output  CNT_WIDTH  number of load-use bubbles inserted, saturating.

Behaviour:
- Reset (rst=0, asynchronous): all ex_* outputs 0, ex_valid 0, bubble_count 0. Takes effect immediately and independent of clk, including mid-hold or mid-stall. The instruction in ID/EX is lost; upstream refetch is the controller's responsibility.

Operand bypass (combinational, before the register):
- op1 = 0 if id_rs==0.
- Otherwise op1 = wb_data if wb_we && wb_rd==id_rs.
- Otherwise op1 = rf_read_data1.
- op2 is computed identically using id_rt and rf_read_data2.
- wb_rd==0 never bypasses.

Load-use hazard (combinational):
- hazard = id_valid & ex_valid & ex_mem_read & ex_dest!=0 & ((id_use_rs & id_rs==ex_dest) | (id_use_rt & id_rt==ex_dest)).
- id_stall = (hazard | ex_hold) & ~flush.

ID/EX update on each rising edge, in priority order:
1. flush=1: ex_valid<=0, ex_reg_we<=0, ex_mem_read<=0 (bubble). Data fields don't-care; implementation clears them to 0. Flush overrides ex_hold.
2. ex_hold=1: all ID/EX fields keep their value.
3. hazard=1: insert bubble (ex_valid, ex_reg_we, ex_mem_read <=0). The ID instruction is re-presented next cycle, and its operands are re-read and re-bypassed then.
4. Otherwise: capture op1, op2, id_rs, id_rt, id_dest, id_imm. ex_valid<=id_valid; ex_reg_we<=id_reg_we&id_valid; ex_mem_read<=id_mem_read&id_valid.

Latency and stall behaviour:
- Latency is 1 cycle from ID to EX outputs.
- A load-use stall lasts exactly 1 cycle. After the bubble, ex_mem_read=0, so the hazard clears.

bubble_count:
- Increments by 1 on each edge where case 3 is taken (not flush, not hold).
- Saturates at all-ones and never wraps.

Test Plan:
- Reset mid-operation: load ex_rs_data=0x1234, then drop rst between edges -> all outputs 0 immediately, without waiting for a clk edge; ex_valid=0 after release until the next valid capture.
- WB bypass: rf_read_data1=0x0, wb_we=1, wb_rd=5=id_rs, wb_data=0xDEADBEEF -> ex_rs_data=0xDEADBEEF next cycle. Same stimulus with wb_rd=0 and id_rs=0 -> ex_rs_data=0.
- Load-use: ID/EX holds lw with dest r8; ID issues add reading rt=r8 with id_use_rt=1 -> id_stall=1 for one cycle, ex_valid=0 bubble, bubble_count=1, add captured the following edge. Same case with id_use_rt=0 -> no stall.
- Flush versus hold: flush=1 together with ex_hold=1 -> ex_valid=0, id_stall=0 next edge. ex_hold=1 alone for 3 cycles -> ID/EX fields unchanged and id_stall=1 throughout.
- Counter saturation: CNT_WIDTH=4, force 17 consecutive load-use stalls -> bubble_count stops at 15.
- Invalid slot: id_valid=0 with id_reg_we=1 -> ex_valid=0 and ex_reg_we=0 captured.
